pc_unit: RTL and testbench

- Parametrised program-counter unit for the multicycle CPU datapath; successor to the single 16-bit PC register.
- Holds the PC, selects the next PC from sequential, branch, jump, or return sources, and honours a write enable (stall).
- Adds a small circular return-address stack (RAS) that is pushed on jump-and-link and popped on return.
- Sits between the control FSM and instruction fetch.

---
 rtl/pc_unit_pkg.sv | 17 +
 rtl/pc_ras.sv | 71 +++++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared definitions for the program-counter unit.
//   - next-PC source encoding (next_sel_e) used by pc_unit and its benches
//   - default parameter values for the PC datapath
package pc_unit_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_RET    = 2'd3
  } next_sel_e;

  localparam int PC_W_DEF      = 16;
  localparam int INC_DEF       = 1;
  localparam int RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO) for pc_unit.
// Ports:
//   clk, reset        clock, async active-high reset
//   push, pop         one operation per cycle; push wins if both are set
//   push_data         return address to store
//   top_data          most recently pushed valid entry (combinational)
//   empty, full       occupancy, derived from the registered count
//   ovf, unf          sticky: push while full / pop while empty
// A push while full overwrites the oldest entry, so the newest entry is
// always available. RAS_DEPTH must be a power of two, at least 2.
module pc_ras #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;   // next free slot; top entry sits just below
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  assign top_ptr  = wr_ptr - PTR_W'(1);
  assign top_data = mem[top_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);

  // Entries carry no reset; they are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (push) begin
      // Pointer wraps naturally, so a push while full replaces the oldest entry.
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr - PTR_W'(1);
        count  <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC select and a return-address stack.
// Ports:
//   clk, reset        clock, async active-high reset (pc <- RESET_VEC)
//   pc_write          update enable; 0 freezes pc, RAS and flags
//   next_sel          0 SEQ, 1 BRANCH, 2 JUMP, 3 RET
//   branch_target     BRANCH destination
//   jump_target       JUMP destination, and RET destination when RAS is empty
//   link              with JUMP, push pc+INC onto the RAS
//   pc                current PC (registered)
//   pc_plus_inc       pc+INC, combinational, wraps modulo 2^PC_W
//   ras_empty/full    RAS occupancy
//   ras_ovf/ras_unf   sticky RAS overflow / underflow
// Optional (macro PC_UNIT_HISTORY_EN):
//   prev_pc           pc before the most recent update (reset RESET_VEC)
//   upd_cnt           number of updates, wrapping 32-bit counter
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              INC       = INC_DEF,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic [1:0]      next_sel,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  input  logic            link,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus_inc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
`ifdef PC_UNIT_HISTORY_EN
  ,
  output logic [PC_W-1:0] prev_pc,
  output logic [31:0]     upd_cnt
`endif
);
  next_sel_e       sel;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;

  assign sel         = next_sel_e'(next_sel);
  assign pc_plus_inc = pc + PC_W'(INC);

  // link only matters on JUMP; a RET on an empty stack still reaches the RAS
  // so that it can record the underflow.
  assign ras_push = pc_write && (sel == SEL_JUMP) && link;
  assign ras_pop  = pc_write && (sel == SEL_RET);

  always_comb begin
    pc_next = pc_plus_inc;
    case (sel)
      SEL_SEQ:    pc_next = pc_plus_inc;
      SEL_BRANCH: pc_next = branch_target;
      SEL_JUMP:   pc_next = jump_target;
      SEL_RET:    pc_next = ras_empty ? jump_target : ras_top;
      default:    pc_next = pc_plus_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VEC;
    end else if (pc_write) begin
      pc <= pc_next;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_inc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

`ifdef PC_UNIT_HISTORY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc <= RESET_VEC;
      upd_cnt <= '0;
    end else if (pc_write) begin
      prev_pc <= pc;
      upd_cnt <= upd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (RESET_VEC = 0x0010,
// RAS_DEPTH = 4). Stimulus pushes hand-computed expectations tagged with the
// clock cycle they apply to; a negedge monitor pops and compares them.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam logic [15:0] RV = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b0;
  logic [1:0]  next_sel = 2'd0;
  logic [15:0] branch_target = '0;
  logic [15:0] jump_target = '0;
  logic        link = 1'b0;
  logic [15:0] pc;
  logic [15:0] pc_plus_inc;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_UNIT_HISTORY_EN
  logic [15:0] prev_pc;
  logic [31:0] upd_cnt;
`endif

  pc_unit #(
    .PC_W      (16),
    .RESET_VEC (RV),
    .INC       (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .next_sel      (next_sel),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .link          (link),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_ovf       (ras_ovf),
    .ras_unf       (ras_unf)
`ifdef PC_UNIT_HISTORY_EN
    ,
    .prev_pc       (prev_pc),
    .upd_cnt       (upd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [15:0] pc;
    logic [15:0] ppi;
    logic        e, f, o, u;
    logic [15:0] prev;
    logic [31:0] upd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mx;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_pc = RV;
  logic [15:0] m_prev = RV;
  logic [31:0] m_upd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int tag, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, tag, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      mx = sb.pop_front();
      if (mx.tag < cyc) begin
        chk("stale_entry", mx.tag, 32'(cyc), 32'(mx.tag));
      end else begin
        chk("pc",          mx.tag, 32'(pc),          32'(mx.pc));
        chk("pc_plus_inc", mx.tag, 32'(pc_plus_inc), 32'(mx.ppi));
        chk("ras_empty",   mx.tag, 32'(ras_empty),   32'(mx.e));
        chk("ras_full",    mx.tag, 32'(ras_full),    32'(mx.f));
        chk("ras_ovf",     mx.tag, 32'(ras_ovf),     32'(mx.o));
        chk("ras_unf",     mx.tag, 32'(ras_unf),     32'(mx.u));
`ifdef PC_UNIT_HISTORY_EN
        chk("prev_pc",     mx.tag, 32'(prev_pc),     32'(mx.prev));
        chk("upd_cnt",     mx.tag, upd_cnt,          mx.upd);
`endif
      end
    end
  end

  task automatic expect_reset(input int tag);
    exp_t x;
    m_pc   = RV;
    m_prev = RV;
    m_upd  = '0;
    x.tag = tag; x.pc = RV; x.ppi = RV + 16'd1;
    x.e = 1'b1; x.f = 1'b0; x.o = 1'b0; x.u = 1'b0;
    x.prev = RV; x.upd = '0;
    sb.push_back(x);
  endtask

  task automatic step(input logic pw, input logic [1:0] sel, input logic [15:0] bt,
                      input logic [15:0] jt, input logic lk, input logic [15:0] epc,
                      input logic e, input logic f, input logic o, input logic u);
    exp_t x;
    @(negedge clk);
    pc_write = pw; next_sel = sel; branch_target = bt; jump_target = jt; link = lk;
    if (pw) begin
      m_prev = m_pc;
      m_upd  = m_upd + 32'd1;
    end
    m_pc = epc;
    x.tag = cyc + 1; x.pc = epc; x.ppi = epc + 16'd1;
    x.e = e; x.f = f; x.o = o; x.u = u;
    x.prev = m_prev; x.upd = m_upd;
    sb.push_back(x);
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    expect_reset(cyc + 1);
    @(negedge clk);
    reset = 1'b0;

    // sequential from RESET_VEC
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0011, 1, 0, 0, 0);
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0012, 1, 0, 0, 0);
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0013, 1, 0, 0, 0);
    // stall, then branch
    step(0, SEL_BRANCH, 16'h1234, 16'h0,    0, 16'h0013, 1, 0, 0, 0);
    step(0, SEL_BRANCH, 16'h1234, 16'h0,    0, 16'h0013, 1, 0, 0, 0);
    step(1, SEL_BRANCH, 16'h1234, 16'h0,    0, 16'h1234, 1, 0, 0, 0);
    // stalled linked jump must not push
    step(0, SEL_JUMP,   16'h0,    16'h5555, 1, 16'h1234, 1, 0, 0, 0);
    // call / return
    step(1, SEL_BRANCH, 16'h0020, 16'h0,    0, 16'h0020, 1, 0, 0, 0);
    step(1, SEL_JUMP,   16'h0,    16'h0100, 1, 16'h0100, 0, 0, 0, 0);
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0101, 0, 0, 0, 0);
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0102, 0, 0, 0, 0);
    step(1, SEL_RET,    16'h0,    16'h0BAD, 0, 16'h0021, 1, 0, 0, 0);
    // link ignored on BRANCH
    step(1, SEL_BRANCH, 16'h0001, 16'h0,    1, 16'h0001, 1, 0, 0, 0);
    // five linked jumps into a 4-deep stack
    step(1, SEL_JUMP,   16'h0,    16'h0011, 1, 16'h0011, 0, 0, 0, 0);
    step(1, SEL_JUMP,   16'h0,    16'h0021, 1, 16'h0021, 0, 0, 0, 0);
    step(1, SEL_JUMP,   16'h0,    16'h0031, 1, 16'h0031, 0, 0, 0, 0);
    step(1, SEL_JUMP,   16'h0,    16'h0041, 1, 16'h0041, 0, 1, 0, 0);
    step(1, SEL_JUMP,   16'h0,    16'h0051, 1, 16'h0051, 0, 1, 1, 0);
    // four returns, newest first, then underflow to jump_target
    step(1, SEL_RET,    16'h0,    16'h0BAD, 0, 16'h0042, 0, 0, 1, 0);
    step(1, SEL_RET,    16'h0,    16'h0BAD, 0, 16'h0032, 0, 0, 1, 0);
    step(1, SEL_RET,    16'h0,    16'h0BAD, 0, 16'h0022, 0, 0, 1, 0);
    step(1, SEL_RET,    16'h0,    16'h0BAD, 0, 16'h0012, 1, 0, 1, 0);
    step(1, SEL_RET,    16'h0,    16'h0BAD, 0, 16'h0BAD, 1, 0, 1, 1);
    // wrap at top of address space
    step(1, SEL_BRANCH, 16'hFFFF, 16'h0,    0, 16'hFFFF, 1, 0, 1, 1);
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0000, 1, 0, 1, 1);
    // two pushes, hold, then asynchronous reset mid-cycle
    step(1, SEL_JUMP,   16'h0,    16'h0200, 1, 16'h0200, 0, 0, 1, 1);
    step(1, SEL_JUMP,   16'h0,    16'h0300, 1, 16'h0300, 0, 0, 1, 1);
    step(0, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0300, 0, 0, 1, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    expect_reset(cyc);
    @(negedge clk);
    #1;
    reset = 1'b0;
    step(1, SEL_SEQ,    16'h0,    16'h0,    0, 16'h0011, 1, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
